// File: rtl/pzbcm_multi_counter_pkg.sv
`default_nettype none
// ============================================================================
// pzbcm_multi_counter_pkg : boundary-mode enum and delta-width helper
// Revision: 1.0
// ============================================================================
package pzbcm_multi_counter_pkg;

    typedef enum logic {
        WRAP     = 1'b0,
        SATURATE = 1'b1
    } pzbcm_counter_mode_e;

    // Signed delta width: room for the count, the step and a sign/carry guard.
    function automatic int calc_delta_width(input int width, input int step_width);
        return width + step_width + 2;
    endfunction

endpackage
`default_nettype wire

// File: rtl/pzbcm_multi_counter_unit.sv
`default_nettype none
// ============================================================================
// pzbcm_multi_counter_unit : one up/down counter channel with wrap/saturate
// Revision: 1.0
// ============================================================================
module pzbcm_multi_counter_unit
    import pzbcm_multi_counter_pkg::*;
#(
    parameter int                  WIDTH         = 8,
    parameter int                  STEP_WIDTH    = 4,
    parameter logic [WIDTH-1:0]    MAX_COUNT     = '1,
    parameter logic [WIDTH-1:0]    MIN_COUNT     = '0,
    parameter logic [WIDTH-1:0]    INITIAL_COUNT = MIN_COUNT,
    parameter pzbcm_counter_mode_e MODE          = WRAP
) (
    input  logic                  i_clk,
    input  logic                  i_rst,
    input  logic                  i_clear,
    input  logic                  i_set,
    input  logic [WIDTH-1:0]      i_set_value,
    input  logic                  i_up,
    input  logic                  i_down,
    input  logic [STEP_WIDTH-1:0] i_up_step,
    input  logic [STEP_WIDTH-1:0] i_down_step,
    input  logic                  i_flag_clear,
    output logic [WIDTH-1:0]      o_count,
    output logic [WIDTH-1:0]      o_count_next,
    output logic                  o_wrap_around,
    output logic                  o_saturated,
    output logic                  o_boundary_hit
);

    localparam int DW = calc_delta_width(WIDTH, STEP_WIDTH);

    localparam logic signed [DW-1:0] c_max  = $signed(DW'(MAX_COUNT));
    localparam logic signed [DW-1:0] c_min  = $signed(DW'(MIN_COUNT));
    localparam logic signed [DW-1:0] c_span = c_max - c_min + $signed(DW'(1));

    logic [WIDTH-1:0]     r_count;
    logic                 r_flag;
    logic [WIDTH-1:0]     w_base;
    logic signed [DW-1:0] w_up;
    logic signed [DW-1:0] w_down;
    logic signed [DW-1:0] w_delta;
    logic signed [DW-1:0] w_raw;
    logic [WIDTH-1:0]     w_count_next;
    logic                 w_wrap;
    logic                 w_sat;

    // While reset is held the next value is computed from the reset value.
    assign w_base  = i_rst ? INITIAL_COUNT : r_count;
    assign w_up    = i_up   ? $signed(DW'(i_up_step))   : '0;
    assign w_down  = i_down ? $signed(DW'(i_down_step)) : '0;
    assign w_delta = w_up - w_down;
    assign w_raw   = $signed(DW'(w_base)) + w_delta;

    always_comb begin
        w_count_next = w_base;
        w_wrap       = 1'b0;
        w_sat        = 1'b0;
        if (i_clear) begin
            w_count_next = INITIAL_COUNT;
        end else if (i_set) begin
            w_count_next = i_set_value;
        end else if (w_delta == '0) begin
            w_count_next = w_base;
        end else if (w_raw > c_max) begin
            if (MODE == SATURATE) begin
                w_count_next = MAX_COUNT;
                w_sat        = 1'b1;
            end else begin
                w_count_next = WIDTH'(w_raw - c_span);
                w_wrap       = 1'b1;
            end
        end else if (w_raw < c_min) begin
            if (MODE == SATURATE) begin
                w_count_next = MIN_COUNT;
                w_sat        = 1'b1;
            end else begin
                w_count_next = WIDTH'(w_raw + c_span);
                w_wrap       = 1'b1;
            end
        end else begin
            w_count_next = WIDTH'(w_raw);
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_count <= INITIAL_COUNT;
            r_flag  <= 1'b0;
        end else begin
            r_count <= w_count_next;
            // A new event outranks a coincident flag clear.
            if (w_wrap || w_sat) begin
                r_flag <= 1'b1;
            end else if (i_flag_clear) begin
                r_flag <= 1'b0;
            end
        end
    end

    assign o_count        = r_count;
    assign o_count_next   = w_count_next;
    assign o_wrap_around  = w_wrap;
    assign o_saturated    = w_sat;
    assign o_boundary_hit = r_flag;

endmodule
`default_nettype wire

// File: rtl/pzbcm_multi_counter.sv
`default_nettype none
// ============================================================================
// pzbcm_multi_counter : CHANNELS independent bounded up/down counters
// Revision: 1.0
// ============================================================================
module pzbcm_multi_counter
    import pzbcm_multi_counter_pkg::*;
#(
    parameter int                  CHANNELS      = 4,
    parameter int                  WIDTH         = 8,
    parameter int                  STEP_WIDTH    = 4,
    parameter logic [WIDTH-1:0]    MAX_COUNT     = '1,
    parameter logic [WIDTH-1:0]    MIN_COUNT     = '0,
    parameter logic [WIDTH-1:0]    INITIAL_COUNT = MIN_COUNT,
    parameter pzbcm_counter_mode_e MODE          = WRAP
) (
    input  logic                                 i_clk,
    input  logic                                 i_rst,
    input  logic [CHANNELS-1:0]                  i_clear,
    input  logic [CHANNELS-1:0]                  i_set,
    input  logic [CHANNELS-1:0][WIDTH-1:0]       i_set_value,
    input  logic [CHANNELS-1:0]                  i_up,
    input  logic [CHANNELS-1:0]                  i_down,
    input  logic [CHANNELS-1:0][STEP_WIDTH-1:0]  i_up_step,
    input  logic [CHANNELS-1:0][STEP_WIDTH-1:0]  i_down_step,
    input  logic [CHANNELS-1:0]                  i_flag_clear,
    output logic [CHANNELS-1:0][WIDTH-1:0]       o_count,
    output logic [CHANNELS-1:0][WIDTH-1:0]       o_count_next,
    output logic [CHANNELS-1:0]                  o_wrap_around,
    output logic [CHANNELS-1:0]                  o_saturated,
    output logic [CHANNELS-1:0]                  o_boundary_hit
);

    for (genvar g = 0; g < CHANNELS; g++) begin : g_channel
        pzbcm_multi_counter_unit #(
            .WIDTH         (WIDTH),
            .STEP_WIDTH    (STEP_WIDTH),
            .MAX_COUNT     (MAX_COUNT),
            .MIN_COUNT     (MIN_COUNT),
            .INITIAL_COUNT (INITIAL_COUNT),
            .MODE          (MODE)
        ) u_unit (
            .i_clk          (i_clk),
            .i_rst          (i_rst),
            .i_clear        (i_clear[g]),
            .i_set          (i_set[g]),
            .i_set_value    (i_set_value[g]),
            .i_up           (i_up[g]),
            .i_down         (i_down[g]),
            .i_up_step      (i_up_step[g]),
            .i_down_step    (i_down_step[g]),
            .i_flag_clear   (i_flag_clear[g]),
            .o_count        (o_count[g]),
            .o_count_next   (o_count_next[g]),
            .o_wrap_around  (o_wrap_around[g]),
            .o_saturated    (o_saturated[g]),
            .o_boundary_hit (o_boundary_hit[g])
        );
    end

endmodule
`default_nettype wire

// File: doc/pzbcm_multi_counter.md
PZBCM_MULTI_COUNTER -- requirements
Module: pzbcm_multi_counter

Interface
REQ-001 Parameter CHANNELS, default 4: number of independent counter channels, at least 1.
REQ-002 Parameter WIDTH, default 8: count width in bits.
REQ-003 Parameter STEP_WIDTH, default 4: width of the up/down step operands.
REQ-004 Parameter MAX_COUNT, default all-ones: upper bound of the count range, shared by all channels.
REQ-005 Parameter MIN_COUNT, default 0: lower bound of the count range; MIN_COUNT < MAX_COUNT.
REQ-006 Parameter INITIAL_COUNT, default MIN_COUNT: value taken at reset and on clear.
REQ-007 Parameter MODE, default WRAP: boundary mode, WRAP or SATURATE (package enum).
REQ-008 i_clk  input  1  clock; the block uses one clock only.
REQ-009 i_rst  input  1  reset, synchronous and active-high.
REQ-010 i_clear  input  CHANNELS  per-channel clear to INITIAL_COUNT.
REQ-011 i_set  input  CHANNELS  per-channel load.
REQ-012 i_set_value  input  CHANNELS x WIDTH  per-channel load value.
REQ-013 i_up / i_down  input  CHANNELS each  per-channel increment / decrement request.
REQ-014 i_up_step / i_down_step  input  CHANNELS x STEP_WIDTH each  per-channel step amounts.
REQ-015 i_flag_clear  input  CHANNELS  clears the per-channel sticky flag.
REQ-016 o_count / o_count_next  output  CHANNELS x WIDTH each  current count / next count.
REQ-017 o_wrap_around  output  CHANNELS  combinational pulse: a wrap occurs this cycle.
REQ-018 o_saturated  output  CHANNELS  combinational pulse: a clamp occurs this cycle.
REQ-019 o_boundary_hit  output  CHANNELS  registered sticky flag: a wrap or clamp has occurred.

Function
REQ-020 Channels SHALL be fully independent; per channel, count_next SHALL be registered into count on every clock edge.
REQ-021 Priority per channel SHALL be: clear, then set, then step; with none active, count holds.
REQ-022 Net delta SHALL be (i_up ? up_step : 0) - (i_down ? down_step : 0), computed signed, WIDTH+STEP_WIDTH+2 bits wide; no truncation before bound checks.
REQ-023 Raw sum = count + delta; if MIN_COUNT <= raw sum <= MAX_COUNT, count_next = raw sum, and both event pulses are 0.
REQ-024 WRAP mode, raw sum > MAX_COUNT: count_next = MIN_COUNT + (raw sum - MAX_COUNT - 1); o_wrap_around = 1.
REQ-025 WRAP mode, raw sum < MIN_COUNT: count_next = MAX_COUNT - (MIN_COUNT - raw sum - 1); o_wrap_around = 1.
REQ-026 Wrap behaviour is defined only for |delta| <= MAX_COUNT - MIN_COUNT + 1; the verification environment SHALL flag any violation with an assertion.
REQ-027 SATURATE mode: count_next SHALL clamp to MAX_COUNT or MIN_COUNT; o_saturated = 1 only when raw sum lies outside the range.
REQ-028 Clear or set active SHALL force both o_wrap_around and o_saturated to 0.
REQ-029 The set value is loaded unchecked; an out-of-range value is handled by subsequent steps per REQ-023..027.
REQ-030 o_boundary_hit SHALL set the cycle after an event pulse and remain set until i_flag_clear; if the event and i_flag_clear coincide, set wins.
REQ-031 Equal up and down steps, or a zero step, SHALL leave count unchanged with no events.

Reset
REQ-032 On i_rst high at a clock edge, every count = INITIAL_COUNT and o_boundary_hit = 0; reset overrides all other inputs, including mid-operation.
REQ-033 During and after reset, o_count_next SHALL reflect the inputs applied to INITIAL_COUNT; the event pulses SHALL follow REQ-023..028.

Structure
REQ-034 Package pzbcm_multi_counter_pkg SHALL hold the mode enum (WRAP, SATURATE) and the signed delta width function.
REQ-035 Sub-module pzbcm_multi_counter_unit SHALL implement one channel; the top SHALL instantiate it CHANNELS times by generate.

Verification (WIDTH=4, MIN=2, MAX=13, STEP_WIDTH=4)
REQ-036 WRAP, count 12, up step 3 -> o_count_next 3, o_wrap_around 1, o_boundary_hit 1 the next cycle.
REQ-037 WRAP, count 3, down step 4 -> next 11, wrap pulse 1; up step 5 with down step 2 at count 5 -> next 8, no pulse.
REQ-038 SATURATE, count 12, up step 3 -> next 13, o_saturated 1; then up step 1 at 13 -> stays 13, pulse 1.
REQ-039 Clear, set 9 and up all asserted together -> next INITIAL_COUNT, no pulses; set alone with 9 -> 9.
REQ-040 CHANNELS=4, distinct stimulus per channel -> no cross-channel effect; i_rst asserted mid-stepping -> all counts 2, flags 0 the next cycle.
